// File: rtl/clk_div_multi.sv
// ---------------------------------------------------------------------------
// clk_div_multi
//
// Multi-channel clock-enable generator. Each of NUM_CH channels produces a
// square wave of period 2*H system-clock cycles, plus a one-cycle tick in
// the cycle the wave rises. H is programmable per channel at runtime. A new
// H is held as "pending" and only becomes active at a full-period boundary
// (the falling toggle), so a running output never shows a short pulse.
//
// Parameters
//   NUM_CH   : number of channels (1..16, limited by the 4-bit div_ch)
//   DIV_W    : width of the half-period divisor and of each channel counter
//   DEF_HALF : half-period loaded at reset (12500 -> 1 kHz from 25 MHz)
//
// Ports
//   clk      : system clock, all state updates on the rising edge
//   rst      : synchronous reset, active-high
//   en       : per-channel run enable (level)
//   sync     : one-cycle strobe, restarts all channels phase-aligned
//   div_wr   : divisor write strobe
//   div_ch   : channel addressed by div_wr (values >= NUM_CH are ignored)
//   div_val  : new half-period H in clk cycles (0 parks the channel)
//   clk_o    : per-channel square wave, registered
//   tick_o   : per-channel one-cycle pulse on the 0->1 edge of clk_o
//   pend_o   : per-channel flag, divisor written but not yet active
// ---------------------------------------------------------------------------
module clk_div_multi #(
  parameter int          NUM_CH   = 4,
  parameter int          DIV_W    = 16,
  parameter int unsigned DEF_HALF = 12500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              div_wr,
  input  logic [3:0]        div_ch,
  input  logic [DIV_W-1:0]  div_val,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] pend_o
);

  // Per-channel run state. A channel runs only while enabled and holding a
  // nonzero active half-period.
  localparam logic [0:0] ST_STOP = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [DIV_W-1:0] RST_HALF = DIV_W'(DEF_HALF);
  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch

    logic [DIV_W-1:0] cnt_q,   cnt_d;
    logic [DIV_W-1:0] act_h_q, act_h_d;
    logic [DIV_W-1:0] pnd_h_q, pnd_h_d;
    logic             clk_q,   clk_d;
    logic             tick_q,  tick_d;
    logic             pend_q,  pend_d;

    logic [0:0]       state;
    logic             wr_hit;
    logic             at_end;
    logic             apply_now;
    logic [DIV_W-1:0] apply_h;

    assign wr_hit = div_wr && (div_ch == 4'(c));
    assign state  = (en[c] && (act_h_q != '0)) ? ST_RUN : ST_STOP;

    // Only meaningful in RUN, where act_h_q is nonzero.
    assign at_end = (cnt_q == (act_h_q - ONE));

    // A write landing in the same cycle as an apply event takes effect
    // directly instead of becoming pending.
    assign apply_h = wr_hit ? div_val : pnd_h_q;

    always_comb begin
      cnt_d     = cnt_q;
      clk_d     = clk_q;
      tick_d    = 1'b0;
      pend_d    = pend_q;
      act_h_d   = act_h_q;
      pnd_h_d   = pnd_h_q;
      apply_now = 1'b0;

      if (sync) begin
        cnt_d     = '0;
        clk_d     = 1'b0;
        apply_now = 1'b1;
      end else if (state == ST_STOP) begin
        // Stopped channels discard any partial period and pick up a new
        // divisor immediately, since there is no output phase to protect.
        cnt_d     = '0;
        clk_d     = 1'b0;
        apply_now = 1'b1;
      end else if (at_end) begin
        cnt_d     = '0;
        clk_d     = ~clk_q;
        tick_d    = ~clk_q;
        // Falling toggle closes a full period: safe point to switch H.
        apply_now = clk_q;
      end else begin
        cnt_d = cnt_q + ONE;
      end

      if (apply_now) begin
        act_h_d = apply_h;
        pnd_h_d = apply_h;
        pend_d  = 1'b0;
      end else if (wr_hit) begin
        pnd_h_d = div_val;
        pend_d  = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q   <= '0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
        pend_q  <= 1'b0;
        act_h_q <= RST_HALF;
        pnd_h_q <= RST_HALF;
      end else begin
        cnt_q   <= cnt_d;
        clk_q   <= clk_d;
        tick_q  <= tick_d;
        pend_q  <= pend_d;
        act_h_q <= act_h_d;
        pnd_h_q <= pnd_h_d;
      end
    end

    assign clk_o[c]  = clk_q;
    assign tick_o[c] = tick_q;
    assign pend_o[c] = pend_q;

  end : g_ch

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;

  logic        clk;
  logic        rst;
  logic [3:0]  en;
  logic        sync;
  logic        div_wr;
  logic [3:0]  div_ch;
  logic [15:0] div_val;
  logic [3:0]  clk_o;
  logic [3:0]  tick_o;
  logic [3:0]  pend_o;

  clk_div_multi #(
    .NUM_CH  (4),
    .DIV_W   (16),
    .DEF_HALF(12500)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .sync   (sync),
    .div_wr (div_wr),
    .div_ch (div_ch),
    .div_val(div_val),
    .clk_o  (clk_o),
    .tick_o (tick_o),
    .pend_o (pend_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] cm;
    logic [3:0] ck;
    logic [3:0] tk;
    logic [3:0] pm;
    logic [3:0] pd;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic push_exp(input int c, input logic [3:0] cm, input logic [3:0] ck,
                          input logic [3:0] tk, input logic [3:0] pm,
                          input logic [3:0] pd, input string nm);
    exp_t e;
    int   i;
    e.cyc = c; e.cm = cm; e.ck = ck; e.tk = tk; e.pm = pm; e.pd = pd; e.nm = nm;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > c) i--;
    sb.insert(i, e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: outputs are sampled on the falling edge, after the edge whose
  // count is cyc, and compared against whatever expectations are due.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m = sb.pop_front();
      n_tests++;
      if (m.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", m.nm, m.cyc, cyc);
      end else if ((((clk_o ^ m.ck) & m.cm) !== 4'b0) ||
                   (((tick_o ^ m.tk) & m.cm) !== 4'b0) ||
                   (((pend_o ^ m.pd) & m.pm) !== 4'b0)) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got clk_o=%b tick_o=%b pend_o=%b, want clk_o=%b tick_o=%b pend_o=%b (clk/tick mask %b, pend mask %b)",
                 m.nm, cyc, clk_o, tick_o, pend_o, m.ck, m.tk, m.pd, m.cm, m.pm);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: run exceeded time limit at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  int E, W, S;

  initial begin
    rst = 1'b1; en = 4'b0; sync = 1'b0; div_wr = 1'b0; div_ch = 4'd0; div_val = 16'd0;
    step(2);
    push_exp(cyc + 1, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, "reset_state");
    step(1);

    // Default H=12500 on ch0.
    rst = 1'b0; en = 4'b0001; E = cyc;
    push_exp(E + 12499, 4'hF, 4'b0000, 4'b0000, 4'hF, 4'h0, "def_pre_rise");
    push_exp(E + 12500, 4'hF, 4'b0001, 4'b0001, 4'hF, 4'h0, "def_rise");
    push_exp(E + 12501, 4'hF, 4'b0001, 4'b0000, 4'hF, 4'h0, "def_high");
    push_exp(E + 24999, 4'hF, 4'b0001, 4'b0000, 4'hF, 4'h0, "def_pre_fall");
    push_exp(E + 25000, 4'hF, 4'b0000, 4'b0000, 4'hF, 4'h0, "def_fall");
    push_exp(E + 37500, 4'hF, 4'b0001, 4'b0001, 4'hF, 4'h0, "def_rise2");
    step(37501);

    // Drop en mid-period while high.
    en = 4'b0000;
    push_exp(cyc + 1, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, "en_drop");
    step(1);

    // H=3 on stopped ch1: applied directly.
    div_wr = 1'b1; div_ch = 4'd1; div_val = 16'd3;
    push_exp(cyc + 1, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, "stop_write_no_pend");
    step(1);
    div_wr = 1'b0; en = 4'b0010; E = cyc;
    for (int k = 1; k <= 16; k++)
      push_exp(E + k, 4'hF, {2'b00, ((k % 6) >= 3), 1'b0}, {2'b00, ((k % 6) == 3), 1'b0},
               4'hF, 4'h0, "h3_pattern");

    // Write H=5 with ch1 high and cnt=1.
    wait_until(E + 16);
    W = cyc;
    div_wr = 1'b1; div_ch = 4'd1; div_val = 16'd5;
    push_exp(W + 1,  4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, "h5_pending");
    push_exp(W + 2,  4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, "h5_applied_fall");
    push_exp(W + 6,  4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, "h5_low_end");
    push_exp(W + 7,  4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, "h5_rise");
    push_exp(W + 11, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000, "h5_high_end");
    push_exp(W + 12, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, "h5_fall");
    step(1);

    // ch2: H=4 applied while stopped, then two writes before the boundary.
    div_ch = 4'd2; div_val = 16'd4;
    push_exp(cyc + 1, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, "ch2_stop_apply");
    step(1);
    div_wr = 1'b0; en = 4'b0110; E = cyc;
    push_exp(E + 3,  4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, "ch2_pre_rise");
    push_exp(E + 4,  4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, "ch2_rise");
    push_exp(E + 5,  4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100, "ch2_pend_7");
    push_exp(E + 7,  4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100, "ch2_pend_9");
    push_exp(E + 8,  4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, "ch2_boundary");
    push_exp(E + 15, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, "ch2_not_7");
    push_exp(E + 16, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, "ch2_low_end");
    push_exp(E + 17, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, "ch2_rise_h9");
    push_exp(E + 20, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0000, "ch2_high_h9");
    push_exp(E + 25, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0000, "ch2_high_end");
    push_exp(E + 26, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, "ch2_fall_h9");
    wait_until(E + 4);
    div_wr = 1'b1; div_ch = 4'd2; div_val = 16'd7;
    step(1);
    div_val = 16'd9;
    step(1);
    div_wr = 1'b0;
    wait_until(E + 27);

    // ch0 H=2, ch1 H=4, started out of phase, then sync.
    en = 4'b0000; div_wr = 1'b1; div_ch = 4'd0; div_val = 16'd2;
    step(1);
    div_ch = 4'd1; div_val = 16'd4;
    step(1);
    div_wr = 1'b0; en = 4'b0001;
    step(1);
    en = 4'b0011;
    step(3);
    S = cyc;
    sync = 1'b1; div_wr = 1'b1; div_ch = 4'd1; div_val = 16'd4;
    for (int k = 0; k <= 8; k++)
      push_exp(S + 1 + k, 4'b0011, {2'b00, ((k % 8) >= 4), ((k % 4) >= 2)},
               {2'b00, ((k % 8) == 4), ((k % 4) == 2)}, 4'b0011, 4'b0000, "sync_align");
    step(1);
    sync = 1'b0; div_wr = 1'b0;
    wait_until(S + 10);

    // ch3 H=1, out-of-range write, then H=0 on a boundary.
    div_wr = 1'b1; div_ch = 4'd3; div_val = 16'd1;
    step(1);
    div_wr = 1'b0; en = 4'b1011; E = cyc;
    push_exp(E + 1,  4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, "h1_rise");
    push_exp(E + 2,  4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, "h1_fall");
    push_exp(E + 3,  4'b1000, 4'b1000, 4'b1000, 4'b1111, 4'b0000, "ch7_ignored_pend");
    push_exp(E + 4,  4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, "ch7_h1_fall");
    push_exp(E + 5,  4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, "ch7_h1_kept");
    push_exp(E + 6,  4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, "h0_on_boundary");
    push_exp(E + 7,  4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, "h0_held_low");
    push_exp(E + 12, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, "h0_still_low");
    wait_until(E + 2);
    div_wr = 1'b1; div_ch = 4'd7; div_val = 16'd2;
    step(1);
    div_wr = 1'b0;
    wait_until(E + 5);
    div_wr = 1'b1; div_ch = 4'd3; div_val = 16'd0;
    step(1);
    div_wr = 1'b0;
    wait_until(E + 13);

    // Reset mid-period restores defaults.
    rst = 1'b1;
    push_exp(cyc + 1, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, "rst_mid");
    step(1);
    rst = 1'b0; en = 4'b0001; E = cyc;
    push_exp(E + 12499, 4'hF, 4'b0000, 4'b0000, 4'hF, 4'h0, "rst_def_pre_rise");
    push_exp(E + 12500, 4'hF, 4'b0001, 4'b0001, 4'hF, 4'h0, "rst_def_rise");
    wait_until(E + 12501);

    for (int i = 0; i < 20 && sb.size() > 0; i++) step(1);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expectations left, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
